// File: rtl/note_judge.sv
// -----------------------------------------------------------------------------
// note_judge
//   Rhythm-game hit judge sitting in front of the score counter. Each beat_tick
//   in GAME_PLAY opens a timing window for the note row. Button presses that
//   arrive inside the window are recorded. When the window closes it produces a
//   one-cycle judgement and the updated combo count.
//
// Parameters
//   WINDOW     window length in clock cycles (>= 2)
//   CNT_W      window counter width (2**CNT_W > WINDOW)
//
// Ports
//   clk            system clock
//   rst            asynchronous, active-high reset
//   current_state  game FSM state: 0 IDLE, 1 SONG_SELECT, 2 GAME_PLAY, 3 GAME_OVER
//   beat_tick      one-cycle pulse: the note row is at the hit line
//   note           expected lanes (bit0 lane A, bit1 lane B), sampled on beat_tick
//   btn            raw asynchronous lane buttons, active-high
//   inp            lanes judged as hit; zero outside the hit_valid cycle
//   hit_valid      one-cycle judgement strobe
//   combo          consecutive-clear count, saturating at 255
//   max_combo      highest combo since the last SONG_SELECT
// -----------------------------------------------------------------------------
module note_judge #(
  parameter int WINDOW = 2500000,
  parameter int CNT_W  = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] current_state,
  input  logic       beat_tick,
  input  logic [1:0] note,
  input  logic [1:0] btn,
  output logic [1:0] inp,
  output logic       hit_valid,
  output logic [7:0] combo,
  output logic [7:0] max_combo
);

  localparam logic [1:0] GS_SONG_SELECT = 2'd1;
  localparam logic [1:0] GS_GAME_PLAY   = 2'd2;

  // The beat cycle itself is the first window cycle, so the register starts
  // at WINDOW-2 and the last window cycle is the one where it reads zero.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WINDOW - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    S_WAIT = 1'b0,
    S_OPEN = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_sync1, r_sync2;
  logic [1:0]       r_exp,   w_exp_nxt;
  logic [1:0]       r_got,   w_got_nxt;
  logic             r_stray, w_stray_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [1:0]       r_inp,   w_inp_nxt;
  logic             r_hit_valid;
  logic [7:0]       r_combo, w_combo_nxt;
  logic [7:0]       r_max,   w_max_nxt;

  logic       w_game;
  logic       w_open;
  logic       w_resolve;
  logic [1:0] w_press;
  logic [1:0] w_got_fin;
  logic       w_stray_fin;
  logic       w_clear;
  logic       w_break;

  assign w_game = (current_state == GS_GAME_PLAY);

  // The second synchronizer flop also serves as the previous value for the
  // rising-edge detector, so no dedicated edge register is needed.
  assign w_press = r_sync1 & ~r_sync2;

  // Accumulators including a press in the current cycle; a press in the
  // resolving cycle still belongs to the window being closed.
  assign w_got_fin   = r_got | (w_press & r_exp);
  assign w_stray_fin = r_stray | (|(w_press & ~r_exp));

  assign w_clear = (r_exp != 2'b00) && (w_got_fin == r_exp) && !w_stray_fin;
  assign w_break = ((r_exp != 2'b00) && (w_got_fin != r_exp)) || w_stray_fin;

  // Window FSM: next state and datapath loads.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp;
    w_got_nxt   = r_got;
    w_stray_nxt = r_stray;
    w_cnt_nxt   = r_cnt;
    w_resolve   = 1'b0;
    w_open      = 1'b0;

    unique case (r_state)
      S_WAIT: begin
        if (w_game && beat_tick) w_open = 1'b1;
      end
      S_OPEN: begin
        if (!w_game) begin
          // Leaving GAME_PLAY abandons the window without a judgement.
          w_state_nxt = S_WAIT;
        end else if (beat_tick) begin
          w_resolve = 1'b1;
          w_open    = 1'b1;
        end else if (r_cnt == '0) begin
          w_resolve   = 1'b1;
          w_state_nxt = S_WAIT;
        end else begin
          w_got_nxt   = w_got_fin;
          w_stray_nxt = w_stray_fin;
          w_cnt_nxt   = r_cnt - CNT_ONE;
        end
      end
      default: w_state_nxt = S_WAIT;
    endcase

    if (w_open) begin
      w_state_nxt = S_OPEN;
      w_exp_nxt   = note;
      w_got_nxt   = 2'b00;
      w_stray_nxt = 1'b0;
      w_cnt_nxt   = CNT_LOAD;
    end
  end

  // Judgement and combo bookkeeping.
  always_comb begin
    w_inp_nxt   = w_resolve ? w_got_fin : 2'b00;
    w_combo_nxt = r_combo;
    w_max_nxt   = r_max;

    if (current_state == GS_SONG_SELECT) begin
      w_combo_nxt = 8'd0;
      w_max_nxt   = 8'd0;
    end else if (w_resolve) begin
      if (w_clear) begin
        w_combo_nxt = (r_combo == 8'hFF) ? 8'hFF : r_combo + 8'd1;
      end else if (w_break) begin
        w_combo_nxt = 8'd0;
      end
      if (w_combo_nxt > r_max) w_max_nxt = w_combo_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_WAIT;
      r_sync1     <= 2'b00;
      r_sync2     <= 2'b00;
      r_exp       <= 2'b00;
      r_got       <= 2'b00;
      r_stray     <= 1'b0;
      r_cnt       <= '0;
      r_inp       <= 2'b00;
      r_hit_valid <= 1'b0;
      r_combo     <= 8'd0;
      r_max       <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_state     <= w_state_nxt;
      r_sync1     <= btn;
      r_sync2     <= r_sync1;
      r_exp       <= w_exp_nxt;
      r_got       <= w_got_nxt;
      r_stray     <= w_stray_nxt;
      r_cnt       <= w_cnt_nxt;
      r_inp       <= w_inp_nxt;
      r_hit_valid <= w_resolve;
      r_combo     <= w_combo_nxt;
      r_max       <= w_max_nxt;
    end
  end

  assign inp       = r_inp;
  assign hit_valid = r_hit_valid;
  assign combo     = r_combo;
  assign max_combo = r_max;

endmodule

// File: tb/tb_note_judge.sv
// -----------------------------------------------------------------------------
// tb_note_judge
//   Directed bench for note_judge with WINDOW=8. Each window the stimulus opens
//   pushes the expected judgement (cycle, inp, combo, max_combo) onto a
//   scoreboard; a negedge monitor pops and compares on every hit_valid and
//   flags any strobe that was not expected.
// -----------------------------------------------------------------------------
module tb_note_judge;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] current_state;
  logic       beat_tick;
  logic [1:0] note;
  logic [1:0] btn;
  logic [1:0] inp;
  logic       hit_valid;
  logic [7:0] combo;
  logic [7:0] max_combo;

  note_judge #(.WINDOW(W), .CNT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .current_state (current_state),
    .beat_tick     (beat_tick),
    .note          (note),
    .btn           (btn),
    .inp           (inp),
    .hit_valid     (hit_valid),
    .combo         (combo),
    .max_combo     (max_combo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [1:0] inp;
    logic [7:0] combo;
    logic [7:0] maxc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   m_combo = 0;
  int   m_max   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference judgement: got = expected lanes actually pressed.
  task automatic expect_judge(input int at, input logic [1:0] exp_n,
                              input logic [1:0] got, input bit stray);
    exp_t e;
    if (exp_n != 2'b00 && got == exp_n && !stray) m_combo = (m_combo >= 255) ? 255 : m_combo + 1;
    else if (exp_n != 2'b00 || stray)             m_combo = 0;
    if (m_combo > m_max) m_max = m_combo;
    e.at    = at;
    e.inp   = got;
    e.combo = 8'(m_combo);
    e.maxc  = 8'(m_max);
    sb.push_back(e);
  endtask

  // Monitor: compare every strobe against the scoreboard, and keep inp quiet otherwise.
  always @(negedge clk) begin
    if (!rst) begin
      if (hit_valid) begin
        if (sb.size() == 0) begin
          check("spurious_hit_valid", 32'(hit_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("hit_cycle", 32'(cyc), 32'(e.at));
          check("inp", 32'(inp), 32'(e.inp));
          check("combo", 32'(combo), 32'(e.combo));
          check("max_combo", 32'(max_combo), 32'(e.maxc));
        end
      end else begin
        check("inp_idle", 32'(inp), 32'd0);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) next_cycle();
  endtask

  task automatic beat(input logic [1:0] n);
    beat_tick = 1'b1;
    note      = n;
    next_cycle();
    beat_tick = 1'b0;
    note      = 2'b00;
  endtask

  task automatic press(input logic [1:0] lanes);
    btn = lanes;
    next_cycle();
    btn = 2'b00;
  endtask

  // One full isolated window: beat, press two cycles later, wait past judgement.
  task automatic window(input logic [1:0] n, input logic [1:0] lanes,
                        input logic [1:0] got, input bit stray);
    int t0;
    t0 = cyc;
    expect_judge(t0 + W, n, got, stray);
    beat(n);
    idle(1);
    if (lanes != 2'b00) press(lanes);
    else                idle(1);
    idle(7);
  endtask

  initial begin
    int t0;
    rst           = 1'b1;
    current_state = 2'd2;
    beat_tick     = 1'b0;
    note          = 2'b00;
    btn           = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_inp", 32'(inp), 32'd0);
    check("rst_hit_valid", 32'(hit_valid), 32'd0);
    check("rst_combo", 32'(combo), 32'd0);
    check("rst_max_combo", 32'(max_combo), 32'd0);
    rst = 1'b0;
    idle(2);

    // Single clear.
    window(2'b01, 2'b01, 2'b01, 1'b0);
    check("clear_combo", 32'(combo), 32'd1);
    check("clear_max", 32'(max_combo), 32'd1);

    // Empty row, then a press one cycle after the window closes.
    t0 = cyc;
    expect_judge(t0 + W, 2'b00, 2'b00, 1'b0);
    beat(2'b00);
    idle(7);
    press(2'b01);
    idle(4);
    check("empty_combo_held", 32'(combo), 32'd1);

    // Miss one lane of a chord, then a stray press.
    window(2'b11, 2'b01, 2'b01, 1'b0);
    check("miss_combo", 32'(combo), 32'd0);
    window(2'b01, 2'b11, 2'b01, 1'b1);
    check("stray_combo", 32'(combo), 32'd0);

    // Overlapping beats: second beat resolves the first window early.
    t0 = cyc;
    expect_judge(t0 + 5, 2'b10, 2'b10, 1'b0);
    beat(2'b10);
    press(2'b10);
    idle(2);
    expect_judge(t0 + 12, 2'b01, 2'b00, 1'b0);
    beat(2'b01);
    idle(9);
    check("overlap_combo", 32'(combo), 32'd0);

    // Saturation.
    for (int i = 0; i < 260; i++) window(2'b01, 2'b01, 2'b01, 1'b0);
    check("sat_combo", 32'(combo), 32'd255);
    check("sat_max", 32'(max_combo), 32'd255);
    window(2'b10, 2'b00, 2'b00, 1'b0);
    check("sat_break_combo", 32'(combo), 32'd0);
    check("sat_break_max", 32'(max_combo), 32'd255);
    window(2'b01, 2'b01, 2'b01, 1'b0);

    // Abort by leaving GAME_PLAY mid-window: no strobe, combo frozen.
    beat(2'b01);
    idle(2);
    current_state = 2'd3;
    press(2'b01);
    idle(12);
    check("abort_combo", 32'(combo), 32'd1);
    check("abort_max", 32'(max_combo), 32'd255);

    // SONG_SELECT clears both counters.
    current_state = 2'd1;
    idle(2);
    m_combo = 0;
    m_max   = 0;
    check("select_combo", 32'(combo), 32'd0);
    check("select_max", 32'(max_combo), 32'd0);
    current_state = 2'd2;
    idle(1);
    window(2'b10, 2'b10, 2'b10, 1'b0);

    // Asynchronous reset mid-window.
    beat(2'b01);
    press(2'b01);
    idle(1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_inp", 32'(inp), 32'd0);
    check("arst_hit_valid", 32'(hit_valid), 32'd0);
    check("arst_combo", 32'(combo), 32'd0);
    check("arst_max", 32'(max_combo), 32'd0);
    next_cycle();
    rst = 1'b0;
    idle(12);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
